lsu: RTL and testbench
======================

# lsu

Load/store unit forming the MEM stage of the RV32IM pipeline, sitting between the EX/MEM pipeline register and a variable-latency data bus. Accepts one memory operation from EX/MEM, runs a request/ready bus transaction, and handles byte-lane steering, alignment checking and load sign/zero extension. Stalls the upstream pipeline while a transaction is outstanding and hands the extended load result to MEM/WB.

## Interface
- TIMEOUT, 255: bus watchdog limit in cycles spent in ACCESS without `bus_ready` (≥1); used only with `LSU_TIMEOUT_EN`.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX/MEM holds a valid instruction this cycle.
- ex_memread  in  1  instruction is a load.
- ex_memwrite  in  1  instruction is a store.
- ex_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ex_addr  in  32  effective byte address (ALU result).
- ex_wdata  in  32  store data, forwarded rs2 value.
- ex_rd  in  5  load destination register.
- lsu_stall  out  1  hold IF/ID/EX and EX/MEM.
- wb_valid  out  1  one-cycle pulse: load result valid.
- wb_rd  out  5  load destination.
- wb_data  out  32  extended load data.
- misaligned  out  1  one-cycle pulse: op dropped (misaligned or illegal funct3).
- bus_err  out  1  one-cycle pulse: watchdog expired.
- bus_req  out  1  transaction request, registered.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address, `{addr[31:2],2'b00}`.
- bus_wdata  out  32  lane-replicated store data.
- bus_be  out  4  byte enables (writes only; 0000 on reads).
- bus_ready  in  1  transaction complete; `bus_rdata` valid this cycle.
- bus_rdata  in  32  read data.

## Operation
- States: IDLE, ACCESS.
- IDLE accept: `ex_valid && (ex_memread || ex_memwrite)`. Both set: treated as store.
- Check at accept: H/HU/SH need `addr[0]==0`; W/SW need `addr[1:0]==0`; funct3 011/110/111 (loads) or ≥011 (stores) illegal. Failure → `misaligned` pulses next cycle, no bus activity, no `wb_valid`, state stays IDLE.
- Legal op: latch addr, funct3, rd, we, wdata; go ACCESS.
- Store lanes: SB `wdata` = byte×4, `be = 0001 << addr[1:0]`; SH halfword×2, `be` = 0011 or 1100; SW `be` = 1111.
- ACCESS: `bus_req=1`, bus outputs stable until the cycle `bus_ready=1`, then → IDLE.
- Load extract: `rdata >> (8*addr[1:0])`. B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
- Loads register `wb_data`/`wb_rd` and pulse `wb_valid`. `wb_valid` pulses even if rd=0, because the regfile gates x0. Stores never pulse `wb_valid`.

## Timing
- Reset: state IDLE; `bus_req`, `bus_we`, `wb_valid`, `misaligned`, `bus_err`, `lsu_stall` = 0; `bus_addr`, `bus_wdata`, `wb_data` = 0; `bus_be` = 0000; `wb_rd` = 0.
- Reset mid-transaction: `bus_req` drops immediately; no `wb_valid`.
- `lsu_stall` (combinational) is high:
  - in the IDLE cycle that accepts a legal op;
  - in every ACCESS cycle up to and including the `bus_ready` cycle.
- Accept at cycle N → `bus_req` high at N+1.
- `bus_ready` at cycle M → `wb_valid` at M+1. Zero-wait load: accept N, `wb_valid` N+2.
- In the `wb_valid` cycle the state is IDLE and a new op may be accepted (back-to-back, 2 cycles per op minimum).
- `bus_ready` while IDLE is ignored.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - ACCESS cycle counter, cleared on entry.
  - If `TIMEOUT` cycles pass without `bus_ready`: drop `bus_req`, pulse `bus_err` next cycle, return to IDLE, no `wb_valid`, `lsu_stall` releases.
- Undefined: no counter; ACCESS waits indefinitely; `bus_err` tied 0.

## Test plan
- LB at addr 0x103, `bus_rdata`=0x80AA_BBCC, `bus_ready` same cycle as `bus_req` → `wb_data`=0xFFFF_FF80, `wb_valid` 2 cycles after accept, `lsu_stall` high 2 cycles.
- LHU at 0x102, rdata 0x8001_1234, `bus_ready` after 3 wait cycles → `wb_data`=0x0000_8001; `bus_addr`=0x100 held through waits.
- SB 0x5A at 0x201 → `bus_we`=1, `be`=0010, `bus_wdata`=0x5A5A_5A5A, `bus_addr`=0x200, no `wb_valid`.
- LW at 0x102 → `misaligned` pulse, `bus_req` stays 0, `lsu_stall` never asserts.
- With `LSU_TIMEOUT_EN`, TIMEOUT=4, `bus_ready` held 0 → `bus_req` high 4 cycles, then `bus_err` pulse, state IDLE.
- Assert `rst` during ACCESS of an LW → `bus_req` 0 immediately, no `wb_valid`; next LW after reset completes normally.

Source files
------------

// File: rtl/lsu.sv
// lsu: MEM-stage load/store unit. Takes one memory op from EX/MEM, runs a
// req/ready bus transaction, steers store byte lanes, checks alignment and
// sign/zero-extends load data for MEM/WB.
// Optional bus watchdog: define LSU_TIMEOUT_EN (limit set by TIMEOUT).
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        lsu_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t      r_state;
  logic [1:0]  r_lo;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd;

  logic        w_accept;
  logic        w_we;
  logic        w_f3_ok;
  logic        w_align_ok;
  logic        w_legal;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic [31:0] w_shifted;
  logic [31:0] w_load;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] r_cnt;
  logic          r_bus_err;
  assign bus_err = r_bus_err;
`else
  assign bus_err = 1'b0;
`endif

  assign w_accept = ex_valid && (ex_memread || ex_memwrite);
  // A load+store collision is handled as a store.
  assign w_we     = ex_memwrite;
  assign w_legal  = w_f3_ok && w_align_ok;

  // Stall while accepting a legal op and for the whole bus transaction.
  assign lsu_stall = (r_state == S_ACCESS) ||
                     ((r_state == S_IDLE) && w_accept && w_legal);

  // Legality, alignment and store lane steering for the incoming op.
  always_comb begin
    w_f3_ok    = 1'b0;
    w_align_ok = 1'b1;
    w_wdata    = ex_wdata;
    w_be       = 4'b1111;
    case (ex_funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = !w_we;
      default:                w_f3_ok = 1'b0;
    endcase
    case (ex_funct3[1:0])
      2'b01:   w_align_ok = !ex_addr[0];
      2'b10:   w_align_ok = (ex_addr[1:0] == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
    case (ex_funct3[1:0])
      2'b00: begin
        w_wdata = {4{ex_wdata[7:0]}};
        w_be    = 4'b0001 << ex_addr[1:0];
      end
      2'b01: begin
        w_wdata = {2{ex_wdata[15:0]}};
        w_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = ex_wdata;
        w_be    = 4'b1111;
      end
    endcase
  end

  // Load data: shift addressed lane down, then sign/zero extend.
  always_comb begin
    w_shifted = bus_rdata >> {r_lo, 3'b000};
    case (r_f3)
      3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load = {24'h000000, w_shifted[7:0]};
      3'b101:  w_load = {16'h0000, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  // Control FSM with registered bus and writeback outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lo       <= '0;
      r_f3       <= '0;
      r_rd       <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_be     <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      misaligned <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_cnt      <= '0;
      r_bus_err  <= 1'b0;
`endif
    end else begin
      wb_valid   <= 1'b0;
      misaligned <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_bus_err  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (!w_legal) begin
              misaligned <= 1'b1;
            end else begin
              r_state   <= S_ACCESS;
              r_lo      <= ex_addr[1:0];
              r_f3      <= ex_funct3;
              r_rd      <= ex_rd;
              bus_req   <= 1'b1;
              bus_we    <= w_we;
              bus_addr  <= {ex_addr[31:2], 2'b00};
              bus_wdata <= w_we ? w_wdata : '0;
              bus_be    <= w_we ? w_be : 4'b0000;
`ifdef LSU_TIMEOUT_EN
              r_cnt     <= '0;
`endif
            end
          end
        end
        S_ACCESS: begin
          if (bus_ready) begin
            r_state <= S_IDLE;
            bus_req <= 1'b0;
            if (!bus_we) begin
              wb_valid <= 1'b1;
              wb_rd    <= r_rd;
              wb_data  <= w_load;
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_state   <= S_IDLE;
            bus_req   <= 1'b0;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu. Inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_memread = 1'b0;
  logic        ex_memwrite = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_wdata = '0;
  logic [4:0]  ex_rd = '0;
  logic        lsu_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misaligned;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .lsu_stall(lsu_stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .misaligned(misaligned), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic op(input logic rd_, input logic wr_, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdst);
    ex_valid    = 1'b1;
    ex_memread  = rd_;
    ex_memwrite = wr_;
    ex_funct3   = f3;
    ex_addr     = a;
    ex_wdata    = wd;
    ex_rd       = rdst;
  endtask

  task automatic noop();
    ex_valid    = 1'b0;
    ex_memread  = 1'b0;
    ex_memwrite = 1'b0;
  endtask

  // Run a load with the given number of wait cycles and check the result.
  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] rdata, input int unsigned waits,
                      input logic [31:0] exp);
    cyc();
    op(1'b1, 1'b0, f3, a, 32'h0, 5'd9);
    bus_ready = 1'b0;
    bus_rdata = rdata;
    cyc();
    noop();
    for (int unsigned i = 0; i < waits; i++) cyc();
    bus_ready = 1'b1;
    cyc();
    bus_ready = 1'b0;
    mid();
    chk({tag, "_wbv"}, {31'b0, wb_valid}, 32'd1);
    chk({tag, "_data"}, wb_data, exp);
  endtask

  initial begin
    // Reset
    #2 rst = 1'b1;
    mid();
    chk("rst_req",   {31'b0, bus_req}, 32'd0);
    chk("rst_stall", {31'b0, lsu_stall}, 32'd0);
    chk("rst_flags", {28'b0, wb_valid, misaligned, bus_err, bus_we}, 32'd0);
    chk("rst_addr",  bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_wbd",   wb_data, 32'd0);
    chk("rst_be_rd", {23'b0, bus_be, wb_rd}, 32'd0);
    cyc();
    rst = 1'b0;

    // LB 0x103, zero-wait; bus_ready already high in IDLE is ignored
    cyc();
    op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7);
    bus_ready = 1'b1;
    bus_rdata = 32'h80AA_BBCC;
    mid();
    chk("lb_stall0", {31'b0, lsu_stall}, 32'd1);
    chk("lb_req0",   {31'b0, bus_req}, 32'd0);
    cyc();
    noop();
    mid();
    chk("lb_req1",   {31'b0, bus_req}, 32'd1);
    chk("lb_stall1", {31'b0, lsu_stall}, 32'd1);
    chk("lb_addr",   bus_addr, 32'h0000_0100);
    chk("lb_we_be",  {27'b0, bus_we, bus_be}, 32'd0);
    chk("lb_wbv1",   {31'b0, wb_valid}, 32'd0);
    cyc();
    bus_ready = 1'b0;
    mid();
    chk("lb_wbv2",   {31'b0, wb_valid}, 32'd1);
    chk("lb_data",   wb_data, 32'hFFFF_FF80);
    chk("lb_rd",     {27'b0, wb_rd}, 32'd7);
    chk("lb_stall2", {31'b0, lsu_stall}, 32'd0);
    chk("lb_req2",   {31'b0, bus_req}, 32'd0);
    cyc();
    mid();
    chk("lb_wbv3",   {31'b0, wb_valid}, 32'd0);

    // LHU 0x102, three wait cycles, then back-to-back SB in the wb cycle
    cyc();
    op(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd3);
    bus_rdata = 32'h8001_1234;
    cyc();
    noop();
    for (int unsigned i = 0; i < 3; i++) begin
      mid();
      chk("lhu_wait_req",  {31'b0, bus_req}, 32'd1);
      chk("lhu_wait_addr", bus_addr, 32'h0000_0100);
      chk("lhu_wait_stl",  {31'b0, lsu_stall}, 32'd1);
      cyc();
    end
    bus_ready = 1'b1;
    cyc();
    bus_ready = 1'b0;
    op(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h1234_565A, 5'd0);
    mid();
    chk("lhu_wbv",   {31'b0, wb_valid}, 32'd1);
    chk("lhu_data",  wb_data, 32'h0000_8001);
    chk("lhu_rd",    {27'b0, wb_rd}, 32'd3);
    chk("b2b_stall", {31'b0, lsu_stall}, 32'd1);

    // SB 0x5A at 0x201
    cyc();
    noop();
    bus_ready = 1'b1;
    mid();
    chk("sb_req",   {31'b0, bus_req}, 32'd1);
    chk("sb_we",    {31'b0, bus_we}, 32'd1);
    chk("sb_be",    {28'b0, bus_be}, 32'h2);
    chk("sb_wdata", bus_wdata, 32'h5A5A_5A5A);
    chk("sb_addr",  bus_addr, 32'h0000_0200);
    cyc();
    bus_ready = 1'b0;
    mid();
    chk("sb_nowb",  {31'b0, wb_valid}, 32'd0);
    chk("sb_req2",  {31'b0, bus_req}, 32'd0);

    // SH 0xABCD at 0x202
    cyc();
    op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hFFFF_ABCD, 5'd0);
    cyc();
    noop();
    bus_ready = 1'b1;
    mid();
    chk("sh_be",    {28'b0, bus_be}, 32'hC);
    chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);
    cyc();
    bus_ready = 1'b0;

    // SW at 0x204
    cyc();
    op(1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 5'd0);
    cyc();
    noop();
    bus_ready = 1'b1;
    mid();
    chk("sw_be",    {28'b0, bus_be}, 32'hF);
    chk("sw_wdata", bus_wdata, 32'hCAFE_F00D);
    chk("sw_addr",  bus_addr, 32'h0000_0204);
    cyc();
    bus_ready = 1'b0;

    // Extension variants
    load("lh",  3'b001, 32'h0000_0100, 32'h1234_F00D, 0, 32'hFFFF_F00D);
    load("lbu", 3'b100, 32'h0000_0101, 32'h1234_F00D, 1, 32'h0000_00F0);
    load("lb2", 3'b000, 32'h0000_0100, 32'h1234_F07D, 0, 32'h0000_007D);
    load("lw",  3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF);

    // LW at 0x102: misaligned
    cyc();
    op(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 5'd4);
    mid();
    chk("mis_stall0", {31'b0, lsu_stall}, 32'd0);
    cyc();
    noop();
    mid();
    chk("mis_pulse",  {31'b0, misaligned}, 32'd1);
    chk("mis_req",    {31'b0, bus_req}, 32'd0);
    chk("mis_stall1", {31'b0, lsu_stall}, 32'd0);
    cyc();
    mid();
    chk("mis_end",    {30'b0, misaligned, wb_valid}, 32'd0);

    // Load+store with funct3 100: handled as store, hence illegal
    cyc();
    op(1'b1, 1'b1, 3'b100, 32'h0000_0100, 32'h0, 5'd4);
    cyc();
    noop();
    mid();
    chk("both_mis",   {31'b0, misaligned}, 32'd1);
    chk("both_req",   {31'b0, bus_req}, 32'd0);

    // LH at odd address
    cyc();
    op(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0, 5'd4);
    cyc();
    noop();
    mid();
    chk("lh_mis",     {31'b0, misaligned}, 32'd1);

`ifdef LSU_TIMEOUT_EN
    // Watchdog: TIMEOUT=4 cycles of ACCESS, then bus_err
    cyc();
    op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd5);
    bus_ready = 1'b0;
    cyc();
    noop();
    for (int unsigned i = 0; i < 4; i++) begin
      mid();
      chk("to_req", {31'b0, bus_req}, 32'd1);
      cyc();
    end
    mid();
    chk("to_err",   {31'b0, bus_err}, 32'd1);
    chk("to_req0",  {31'b0, bus_req}, 32'd0);
    chk("to_stall", {31'b0, lsu_stall}, 32'd0);
    chk("to_wbv",   {31'b0, wb_valid}, 32'd0);
    cyc();
    mid();
    chk("to_err0",  {31'b0, bus_err}, 32'd0);
`else
    // No watchdog: a long wait keeps the request up
    cyc();
    op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd5);
    bus_ready = 1'b0;
    bus_rdata = 32'h0BAD_F00D;
    cyc();
    noop();
    for (int unsigned i = 0; i < 10; i++) cyc();
    mid();
    chk("nowd_req", {31'b0, bus_req}, 32'd1);
    chk("nowd_err", {31'b0, bus_err}, 32'd0);
    cyc();
    bus_ready = 1'b1;
    cyc();
    bus_ready = 1'b0;
    mid();
    chk("nowd_data", wb_data, 32'h0BAD_F00D);
`endif

    // Reset during ACCESS of an LW
    cyc();
    op(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd6);
    bus_ready = 1'b0;
    cyc();
    noop();
    mid();
    chk("rm_req1", {31'b0, bus_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rm_req0", {31'b0, bus_req}, 32'd0);
    cyc();
    rst = 1'b0;
    bus_ready = 1'b1;
    bus_rdata = 32'h1111_2222;
    cyc();
    mid();
    chk("rm_nowb", {30'b0, wb_valid, bus_req}, 32'd0);
    cyc();
    bus_ready = 1'b0;
    load("rm_lw", 3'b010, 32'h0000_0400, 32'h3333_4444, 1, 32'h3333_4444);

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
